// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, word-addressed data memory and MEM/WB register.
// Also exposes the EX/MEM and MEM/WB values that the execute stage forwards from.

package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  reg_dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  reg_dest;
    logic              reg_write;
  } mem_wb_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] EX_ALUresult,
  input  logic [31:0] EX_ReadData2,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemtoReg,
  output logic [31:0] EXtoMEM_ALUresult,
  output logic [4:0]  EXtoMEM_RegDest,
  output logic        EXtoMEM_RegWrite,
  output logic        EXtoMEM_MemRead,
  output logic [31:0] WB_ALUresult,
  output logic [4:0]  WB_RegDest,
  output logic        WB_RegWrite
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  ex_mem_t ex_mem_q;
  ex_mem_t ex_mem_d_c;
  mem_wb_t mem_wb_q;
  mem_wb_t mem_wb_d_c;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] word_idx_c;
  logic [DATA_W-1:0]    read_data_c;
  logic                 mem_we_c;

  // Byte offset and high address bits are dropped: word-only access, wrapping address space.
  assign word_idx_c = ex_mem_q.alu_result[ADDR_BITS+1:2];
  assign mem_we_c   = ex_mem_q.mem_write & ~stall & ~reset;

  // Read data is forced to zero for non-loads so uninitialised words never leak.
  always_comb begin
    read_data_c = '0;
    if (ex_mem_q.mem_read) begin
      read_data_c = mem_q[word_idx_c];
    end
  end

  // EX/MEM next value: capture the instruction leaving EX, or hold it while stalled.
  always_comb begin
    ex_mem_d_c = ex_mem_q;
    if (!stall) begin
      ex_mem_d_c.alu_result = EX_ALUresult;
      ex_mem_d_c.store_data = EX_ReadData2;
      ex_mem_d_c.reg_dest   = EX_RegDest;
      ex_mem_d_c.reg_write  = EX_RegWrite;
      ex_mem_d_c.mem_read   = EX_MemRead;
      ex_mem_d_c.mem_write  = EX_MemWrite;
      ex_mem_d_c.mem_to_reg = EX_MemtoReg;
    end
  end

  // MEM/WB next value: retire the MEM instruction, or insert a bubble while stalled.
  always_comb begin
    mem_wb_d_c = '0;
    if (!stall) begin
      mem_wb_d_c.reg_dest  = ex_mem_q.reg_dest;
      mem_wb_d_c.reg_write = ex_mem_q.reg_write;
      mem_wb_d_c.data      = ex_mem_q.mem_to_reg ? read_data_c : ex_mem_q.alu_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d_c;
      mem_wb_q <= mem_wb_d_c;
    end
  end

  // Data memory is deliberately left out of reset; the store only fires on the unstalled edge.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[word_idx_c] <= ex_mem_q.store_data;
    end
  end

  assign EXtoMEM_ALUresult = ex_mem_q.alu_result;
  assign EXtoMEM_RegDest   = ex_mem_q.reg_dest;
  assign EXtoMEM_RegWrite  = ex_mem_q.reg_write;
  assign EXtoMEM_MemRead   = ex_mem_q.mem_read;
  assign WB_ALUresult      = mem_wb_q.data;
  assign WB_RegDest        = mem_wb_q.reg_dest;
  assign WB_RegWrite       = mem_wb_q.reg_write;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS pipeline, sitting directly downstream of the execute stage. It owns the EX/MEM pipeline register, the word-addressed data memory, and the MEM/WB pipeline register. It produces the two forwarding values the execute stage muxes on ForwardA/ForwardB: EXtoMEM_ALUresult from EX/MEM, and WB_ALUresult as final write-back data from MEM/WB. Loads and stores complete in one MEM cycle; a stall input freezes the stage.

## Interface
- ADDR_BITS, 8: word-index width; data memory holds 2^ADDR_BITS 32-bit words.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline registers.
- stall  in  1  hold EX/MEM contents; insert bubble into MEM/WB.
- EX_ALUresult  in  32  ALU result / memory byte address.
- EX_ReadData2  in  32  forwarded store data.
- EX_RegDest  in  5  destination register.
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg  in  1 each  control bits for the instruction leaving EX.
- EXtoMEM_ALUresult  out  32  EX/MEM ALU result (forwarding source, ForwardX=2).
- EXtoMEM_RegDest  out  5  EX/MEM destination (forwarding/hazard compare).
- EXtoMEM_RegWrite  out  1  EX/MEM RegWrite.
- EXtoMEM_MemRead  out  1  EX/MEM MemRead (load-use hazard detection).
- WB_ALUresult  out  32  MEM/WB write-back data (forwarding source, ForwardX=1; register-file write data).
- WB_RegDest  out  5  MEM/WB destination.
- WB_RegWrite  out  1  MEM/WB RegWrite; register-file write enable.

## Operation
- EX/MEM register captures ALUresult, ReadData2, RegDest, RegWrite, MemRead, MemWrite, MemtoReg each edge when stall=0. It holds when stall=1.
- Word index = EXtoMEM_ALUresult[ADDR_BITS+1:2].
  - Bits [1:0] are ignored: accesses are word-only, and a misaligned address hits the containing word.
  - Bits [31:ADDR_BITS+2] are ignored, so addresses wrap modulo 2^(ADDR_BITS+2) bytes.
- Read: combinational from the array at the word index during the MEM cycle.
  - Read data is 0 when MemRead=0, so a non-load never propagates array X.
- Write: the array word at the index takes the stored ReadData2 at the rising edge ending the MEM cycle, iff MemWrite=1, stall=0 and reset=0.
  - Exactly one write per store instruction, regardless of stall length.
- MEM/WB register, updated every edge:
  - stall=0: captures RegDest, RegWrite, and data = MemtoReg ? read data : ALU result.
  - stall=1: captures a bubble (RegWrite=0, RegDest=0, data=0).
- MemRead=1 with MemtoReg=0 is legal; the ALU result is written back.
- MemWrite=1 with RegWrite=1 is legal; both actions occur.
- Data memory is not cleared by reset; contents are undefined until written.

## Timing
- Reset (asynchronous, immediate, no clock needed): every output = 0, all EX/MEM and MEM/WB fields = 0.
- Latency:
  - EX inputs appear on EXtoMEM_* 1 cycle later.
  - They appear on WB_* 2 cycles later (with stall=0).
- A store followed immediately by a load to the same word:
  - The store writes at the edge ending its MEM cycle.
  - The load, in MEM next cycle, reads the new value.
  - No internal bypass is needed.
- Reset asserted while a store sits in EX/MEM: no write occurs. A word already written at an earlier edge keeps its value.
- Reset deasserted: normal capture resumes at the first rising edge with reset=0.
- stall for N cycles: the EXtoMEM_* outputs stay constant for N cycles, and WB_RegWrite=0 during cycles 2..N+1 after stall rises. After stall falls, the held instruction reaches MEM/WB on the next edge.
- A stall that rises while a bubble (all control 0) is in EX/MEM has no visible effect beyond the bubble.

## Test plan
- Store/load round-trip: cycle 0 store (ALUresult=0x10, ReadData2=0xDEADBEEF, MemWrite=1). Cycle 1 load (ALUresult=0x10, MemRead=1, MemtoReg=1, RegWrite=1, RegDest=8). Required: on cycle 3, WB_ALUresult=0xDEADBEEF, WB_RegDest=8, WB_RegWrite=1.
- R-type pass-through: ALUresult=0x1234, RegDest=5, RegWrite=1, MemtoReg=0. Required: EXtoMEM_ALUresult=0x1234 after 1 cycle; WB_ALUresult=0x1234, WB_RegDest=5 after 2 cycles.
- Stall: a store of 0xA5A5A5A5 to 0x20 is held in EX/MEM with stall=1 for 3 cycles, then stall=0. Required: EXtoMEM_* constant during the stall, WB_RegWrite=0 during the bubble, exactly one write. A later load from 0x20 returns 0xA5A5A5A5.
- Wrap/alignment (ADDR_BITS=8): store 0x11111111 to 0x403, then load 0x000. Required: the load returns 0x11111111.
- Reset mid-store:
  - Pre-write 0x0 to 0x40.
  - Put a store of 0xFFFFFFFF to 0x40 in EX/MEM, and assert reset before the next edge.
  - Required: all outputs 0 immediately, even between clock edges.
  - After reset release, a load from 0x40 returns 0x0.
- Load with MemRead=0 and MemtoReg=1 (control corner): required WB_ALUresult=0, no X.
